// File: rtl/uart_cmd_parser_if.sv
// Handshake bundle between the UART RX/TX paths, the register write port and the parser.
interface uart_cmd_parser_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_busy;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       resp_valid;
  logic [7:0] resp_byte;
  logic       busy;
  logic [7:0] err_cnt;

  // The environment side drives the received bytes and the TX busy flag.
  modport master (
    output rx_valid, rx_byte, tx_busy,
    input  wr_valid, wr_addr, wr_data, resp_valid, resp_byte, busy, err_cnt
  );

  // The parser side.
  modport slave (
    input  rx_valid, rx_byte, tx_busy,
    output wr_valid, wr_addr, wr_data, resp_valid, resp_byte, busy, err_cnt
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames SYNC/CMD/ADDR/LEN/DATA/CHK packets from the UART byte stream, checks the XOR
// checksum, bursts the buffered payload out as register writes and returns ACK/NAK.
module uart_cmd_parser #(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  uart_cmd_parser_if.slave bus
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CHK, S_COMMIT, S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, addr_q, addr_d, len_q, len_d;
  logic [7:0]    xor_q, xor_d, ptr_q, ptr_d, err_q, err_d;
  logic          nak_q, nak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    pbuf_q [MAX_LEN];

  logic       in_frame, tmo_fire, rx_ok, drop, nak_emit, store;
  logic [8:0] err_sum;

  // Next-state, field capture, timeout and error accounting.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    len_d    = len_q;
    xor_d    = xor_q;
    ptr_d    = ptr_q;
    nak_d    = nak_q;
    tmo_d    = '0;
    nak_emit = 1'b0;
    store    = 1'b0;

    in_frame = state_q inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_CHK};
    // The timeout takes priority: a byte landing in the firing cycle is lost.
    tmo_fire = in_frame && (tmo_q == TW'(TIMEOUT_CYC - 1));
    rx_ok    = bus.rx_valid && !tmo_fire;
    drop     = bus.rx_valid && (state_q == S_COMMIT || state_q == S_RESP);

    if (in_frame && !bus.rx_valid && !tmo_fire) tmo_d = tmo_q + 1'b1;

    case (state_q)
      S_IDLE: if (rx_ok && bus.rx_byte == SYNC) begin
        state_d = S_CMD;
        xor_d   = '0;
        ptr_d   = '0;
      end
      S_CMD: if (rx_ok) begin
        cmd_d   = bus.rx_byte;
        xor_d   = xor_q ^ bus.rx_byte;
        state_d = S_ADDR;
      end
      S_ADDR: if (rx_ok) begin
        addr_d  = bus.rx_byte;
        xor_d   = xor_q ^ bus.rx_byte;
        state_d = S_LEN;
      end
      S_LEN: if (rx_ok) begin
        len_d = bus.rx_byte;
        xor_d = xor_q ^ bus.rx_byte;
        ptr_d = '0;
        if (bus.rx_byte > 8'(MAX_LEN)) begin
          state_d = S_RESP;
          nak_d   = 1'b1;
        end else if (bus.rx_byte == 8'd0) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (rx_ok) begin
        store = 1'b1;
        xor_d = xor_q ^ bus.rx_byte;
        ptr_d = ptr_q + 8'd1;
        if (ptr_q == len_q - 8'd1) begin
          state_d = S_CHK;
          ptr_d   = '0;
        end
      end
      S_CHK: if (rx_ok) begin
        if (bus.rx_byte == xor_q && cmd_q == CMD_WR) begin
          nak_d   = 1'b0;
          state_d = (len_q == 8'd0) ? S_RESP : S_COMMIT;
        end else begin
          nak_d   = 1'b1;
          state_d = S_RESP;
        end
        ptr_d = '0;
      end
      S_COMMIT: begin
        ptr_d = ptr_q + 8'd1;
        if (ptr_q == len_q - 8'd1) begin
          state_d = S_RESP;
          ptr_d   = '0;
        end
      end
      S_RESP: if (!bus.tx_busy) begin
        nak_emit = nak_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_fire) state_d = S_IDLE;

    // NAK and drop can coincide in RESP; both count, clamped at 0xFF.
    err_sum = {1'b0, err_q} + 9'(drop) + 9'(nak_emit) + 9'(tmo_fire);
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // State and control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      xor_q   <= '0;
      ptr_q   <= '0;
      err_q   <= '0;
      nak_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      xor_q   <= xor_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      nak_q   <= nak_d;
      tmo_q   <= tmo_d;
    end
  end

  // Payload buffer; contents are only read after being written in the same frame.
  always_ff @(posedge clk_i) begin
    if (store) pbuf_q[ptr_q[IW-1:0]] <= bus.rx_byte;
  end

  assign bus.wr_valid   = (state_q == S_COMMIT);
  assign bus.wr_addr    = bus.wr_valid ? addr_q + ptr_q : 8'h00;
  assign bus.wr_data    = bus.wr_valid ? pbuf_q[ptr_q[IW-1:0]] : 8'h00;
  assign bus.resp_valid = (state_q == S_RESP) && !bus.tx_busy;
  assign bus.resp_byte  = bus.resp_valid ? (nak_q ? NAK : ACK) : 8'h00;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.err_cnt    = err_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: frames push expected writes/responses, a
// negedge monitor pops and compares them, and each scenario task checks timing inline.
module tb_uart_cmd_parser;
  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   exp_err = 0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_resp [$];
  logic [7:0]  pl [16];

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Monitor: every write/response must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_valid) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected got addr=%h data=%h", bus.wr_addr, bus.wr_data);
        end else begin
          logic [15:0] e;
          e = exp_wr.pop_front();
          if ({bus.wr_addr, bus.wr_data} !== e) begin
            failures++;
            $display("FAIL wr_data got=%h exp=%h", {bus.wr_addr, bus.wr_data}, e);
          end
        end
      end
      if (bus.resp_valid) begin
        checks++;
        if (exp_resp.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected got=%h", bus.resp_byte);
        end else begin
          logic [7:0] r;
          r = exp_resp.pop_front();
          if (bus.resp_byte !== r || bus.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL resp got=%h tx_busy=%b exp=%h", bus.resp_byte, bus.tx_busy, r);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    step();
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Drives a whole frame from pl[] and pushes what the parser should produce.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] len, input logic use_chk,
                            input logic [7:0] chk_in);
    logic [7:0] x, chk, a;
    x = cmd ^ addr ^ len;
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(addr);
    if (len > MAX_LEN) begin
      exp_resp.push_back(NAK);
      exp_err = sat(exp_err + 1);
      send_byte(len);
      return;
    end
    for (int i = 0; i < len; i++) x = x ^ pl[i];
    chk = use_chk ? chk_in : x;
    if (chk == x && cmd == 8'h01) begin
      for (int i = 0; i < len; i++) begin
        a = addr + 8'(i);
        exp_wr.push_back({a, pl[i]});
      end
      exp_resp.push_back(ACK);
    end else begin
      exp_resp.push_back(NAK);
      exp_err = sat(exp_err + 1);
    end
    send_byte(len);
    for (int i = 0; i < len; i++) send_byte(pl[i]);
    send_byte(chk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_resp.size() != 0 || bus.busy) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout wr_left=%0d resp_left=%0d", exp_wr.size(), exp_resp.size());
    end
    step();
  endtask

  task automatic check_err(input string tag);
    checks++;
    if (bus.err_cnt !== 8'(exp_err)) begin
      failures++;
      $display("FAIL %s err_cnt got=%h exp=%h", tag, bus.err_cnt, 8'(exp_err));
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus.wr_valid, bus.resp_valid, bus.busy, bus.err_cnt, bus.wr_addr, bus.wr_data,
         bus.resp_byte} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got wv=%b rv=%b busy=%b err=%h", bus.wr_valid,
               bus.resp_valid, bus.busy, bus.err_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  // A5 01 10 03 11 22 33 with checksum 0x12 (the XOR of CMD..D2).
  task automatic test_good_frame();
    pl = '{default: 8'h00};
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(8'h01, 8'h10, 8'd3, 1'b1, 8'h12);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.wr_valid !== 1'b1) begin
        failures++;
        $display("FAIL good_wr_cycle%0d wr_valid got=%b exp=1", k, bus.wr_valid);
      end
      step();
    end
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL good_resp_latency resp_valid got=%b exp=1", bus.resp_valid);
    end
    wait_drain();
    check_err("good");
  endtask

  task automatic test_bad_chk();
    pl = '{default: 8'h00};
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(8'h01, 8'h10, 8'd3, 1'b1, 8'h00);
    wait_drain();
    check_err("bad_chk");
  endtask

  task automatic test_addr_wrap();
    pl = '{default: 8'h00};
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
    send_frame(8'h01, 8'hFE, 8'd3, 1'b0, 8'h00);
    wait_drain();
    check_err("addr_wrap");
  endtask

  task automatic test_len_limits();
    // LEN=17: NAK in the cycle right after the LEN byte.
    send_frame(8'h01, 8'h00, 8'h11, 1'b0, 8'h00);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_byte !== NAK) begin
      failures++;
      $display("FAIL len_big_resp got rv=%b byte=%h exp rv=1 byte=%h", bus.resp_valid,
               bus.resp_byte, NAK);
    end
    step();
    // Trailing bytes without 0xA5 must not open a frame.
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL len_big_resync busy got=%b exp=0", bus.busy);
    end
    wait_drain();
    check_err("len_big");
    // LEN == MAX_LEN is accepted in full.
    for (int i = 0; i < 16; i++) pl[i] = 8'(8'h40 + i);
    send_frame(8'h01, 8'h80, 8'd16, 1'b0, 8'h00);
    wait_drain();
    // LEN == 0: ACK, no writes.
    send_frame(8'h01, 8'h40, 8'd0, 1'b0, 8'h00);
    wait_drain();
    check_err("len_limits");
  endtask

  task automatic test_bad_cmd();
    pl = '{default: 8'h00};
    pl[0] = 8'h5A;
    send_frame(8'h02, 8'h20, 8'd1, 1'b0, 8'h00);
    wait_drain();
    check_err("bad_cmd");
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TMO - 1) step();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL tmo_early busy got=%b exp=1", bus.busy);
    end
    step();
    exp_err = sat(exp_err + 1);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_fire busy got=%b exp=0", bus.busy);
    end
    check_err("tmo1");
    // A SYNC byte landing on the firing cycle is swallowed by the timeout.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    repeat (TMO - 1) step();
    send_byte(8'hA5);
    exp_err = sat(exp_err + 1);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_same_cycle busy got=%b exp=0", bus.busy);
    end
    check_err("tmo2");
    pl = '{default: 8'h00};
    pl[0] = 8'h77;
    send_frame(8'h01, 8'h30, 8'd1, 1'b0, 8'h00);
    wait_drain();
  endtask

  task automatic test_tx_busy();
    int seen;
    seen = 0;
    pl = '{default: 8'h00};
    pl[0] = 8'h99;
    bus.tx_busy = 1'b1;
    send_frame(8'h01, 8'h50, 8'd1, 1'b0, 8'h00);
    step();
    for (int k = 0; k < 50; k++) begin
      if (bus.resp_valid !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL tx_busy_hold resp_valid high cycles got=%0d exp=0", seen);
    end
    bus.tx_busy = 1'b0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL tx_busy_release resp_valid got=%b exp=1", bus.resp_valid);
    end
    wait_drain();
  endtask

  task automatic test_drop();
    pl = '{default: 8'h00};
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_frame(8'h01, 8'h60, 8'd3, 1'b0, 8'h00);
    send_byte(8'hA5);  // during COMMIT: dropped
    exp_err = sat(exp_err + 1);
    wait_drain();
    check_err("drop_commit");
    // NAK pulse and a dropped byte in the same cycle count twice.
    send_frame(8'h01, 8'h60, 8'd3, 1'b1, 8'h00);
    send_byte(8'h42);
    exp_err = sat(exp_err + 1);
    wait_drain();
    check_err("drop_nak");
  endtask

  task automatic test_back_to_back();
    pl = '{default: 8'h00};
    pl[0] = 8'hA5; pl[1] = 8'h5A;
    send_frame(8'h01, 8'h70, 8'd2, 1'b0, 8'h00);
    wait_drain();
    pl[0] = 8'hFF; pl[1] = 8'hA5;
    send_frame(8'h01, 8'h72, 8'd2, 1'b0, 8'h00);
    wait_drain();
    check_err("b2b");
  endtask

  task automatic test_saturation();
    while (exp_err < 255) begin
      send_frame(8'h01, 8'h00, 8'h11, 1'b0, 8'h00);
      wait_drain();
    end
    check_err("sat_reach");
    send_frame(8'h01, 8'h00, 8'h11, 1'b0, 8'h00);
    wait_drain();
    check_err("sat_hold");
  endtask

  task automatic test_rst_mid_data();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22);
    rst_n = 1'b0;
    #2;
    exp_err = 0;
    checks++;
    if ({bus.wr_valid, bus.resp_valid, bus.busy, bus.err_cnt} !== '0) begin
      failures++;
      $display("FAIL rst_mid outputs got wv=%b rv=%b busy=%b err=%h", bus.wr_valid,
               bus.resp_valid, bus.busy, bus.err_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
    send_byte(8'h33); send_byte(8'h12);
    repeat (5) step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle busy got=%b exp=0", bus.busy);
    end
    check_err("rst_mid");
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.tx_busy  = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_addr_wrap();
    test_len_limits();
    test_bad_cmd();
    test_timeout();
    test_tx_busy();
    test_drop();
    test_back_to_back();
    test_saturation();
    test_rst_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
